blink_driver: RTL and testbench
===============================

Name: blink_driver

Overview:
- Output-side counterpart to the input conditioning path: it turns single-cycle event strobes from core logic into clean, human-visible pulses on a physical output pin (LED, buzzer, relay driver).
- Each accepted event produces exactly one pulse: a fixed active interval followed by a fixed inactive guard gap.
- Events that arrive while a pulse is in progress are counted and replayed back-to-back, up to a saturating limit.
- Sits between core event sources and the top-level output pin; output is registered and glitch-free.

Parameters:
- ON_CYCLES, 4, clock cycles the output is held active per pulse; must be >= 1.
- OFF_CYCLES, 4, clock cycles the output is held inactive after each pulse (guard gap); must be >= 1.
- PENDING_MAX, 3, maximum queued events; 0 means no queuing.
- ACTIVE, 1, output level while a pulse is on; the idle level is the inverse.

Ports:
- clk  input  1  system clock.
- reset_low  input  1  asynchronous reset, active-low.
- enable  input  1  1 = events accepted; 0 = new events ignored.
- event  input  1  single-cycle strobe requesting one pulse; sampled every clock.
- clear_overflow  input  1  synchronous clear of the overflow flag.
- bit_out  output  1  registered pin drive.
- busy  output  1  high when the state is not IDLE.
- pending  output  max(1,$clog2(PENDING_MAX+1))  count of queued events.
- overflow  output  1  sticky flag: an event was dropped because the queue was full.

Behaviour:
- Reset is asynchronous and active-low.
  - On assertion, immediately: state IDLE, bit_out = ~ACTIVE, busy 0, pending 0, overflow 0, counter 0.
  - Asserting reset mid-pulse truncates the pulse at once.
  - First event is accepted on the first clock edge after deassertion.
- State machine: IDLE, ON, OFF. Counter width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- IDLE:
  - An accepted event (enable=1, event=1) at edge N gives state ON from edge N, with bit_out=ACTIVE for cycles N+1 .. N+ON_CYCLES. Latency is exactly 1 clock.
  - pending is not incremented.
- ON: after exactly ON_CYCLES cycles, go to OFF with bit_out=~ACTIVE.
- OFF: after exactly OFF_CYCLES cycles:
  - if pending>0, decrement pending and go directly to ON (no extra idle cycle);
  - otherwise go to IDLE.
- Accepted event while in ON or OFF:
  - if pending<PENDING_MAX, pending+1;
  - otherwise the event is dropped and overflow is set.
- Accepted event on the same edge that the OFF state consumes a pending entry: pending is unchanged and overflow is not set, even when pending==PENDING_MAX.
- Accepted event on the final OFF cycle with pending==0: go ON directly and do not queue the event.
- PENDING_MAX=0: every event arriving while busy is dropped and sets overflow.
- enable=0:
  - event is ignored (no queueing, no overflow);
  - an in-progress pulse and any already-queued events still drain normally.
- clear_overflow:
  - clears overflow on the next edge;
  - if it coincides with a new drop, overflow stays 1 (set wins).
- bit_out is driven directly from a flop, never from combinational decode.
- busy is 1 throughout ON and OFF, including between queued pulses.

Test Plan:
- Defaults; one event at edge 10 -> bit_out=1 for edges 11-14, 0 for 15-18; busy 1 from 11-18, 0 at 19; pending stays 0.
- Three events during the first pulse -> pending reaches 3; four pulses total, each 4 on / 4 off, back-to-back with no idle gap; overflow stays 0.
- Five events during the first pulse -> pending saturates at 3, overflow=1. A clear_overflow pulse returns overflow to 0; coinciding it with a further drop leaves overflow=1.
- pending=3, event on the final OFF cycle -> pending remains 3, overflow stays 0; the next pulse starts immediately.
- Reset asserted asynchronously mid-ON (between edges) -> bit_out=0, busy=0, pending=0 immediately, without waiting for a clock. An event 1 cycle after deassertion produces a normal pulse.
- enable=0 with 3 events while idle -> no activity. enable=0 during a pulse with pending=2 -> all 3 pulses still complete. ACTIVE=0 build: idle level 1, pulses drive 0.

Source files
------------

// File: rtl/blink_driver.sv
// Stretches single-cycle event strobes into fixed on/off pulses on an output pin.
// Events that arrive during a pulse are queued up to PENDING_MAX. Each queued event replays back-to-back with no idle gap.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | output at idle level, waiting for an event
// ON    | output driven to ACTIVE for ON_CYCLES cycles
// OFF   | guard gap at idle level for OFF_CYCLES cycles
module blink_driver #(
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 4,
  parameter int PENDING_MAX = 3,
  parameter bit ACTIVE      = 1'b1,
  localparam int PW = (PENDING_MAX > 0) ? $clog2(PENDING_MAX + 1) : 1,
  localparam int CW = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          reset_low,
  input  logic          enable,
  input  logic          evt,
  input  logic          clear_overflow,
  output logic          bit_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(PENDING_MAX);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pend_n;
  logic          ovf_n, bit_n;
  logic          accept, cnt_last, drop;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      bit_out  <= ~ACTIVE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pend_n;
      overflow <= ovf_n;
      bit_out  <= bit_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pend_n   = pending;
    drop     = 1'b0;
    accept   = enable & evt;
    cnt_last = (cnt == '0);

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_ON;
          cnt_n   = ON_LOAD;
        end
      end
      S_ON, S_OFF: begin
        if (state == S_OFF && cnt_last) begin
          // End of guard gap: the event on this edge either replaces the consumed entry or starts the next pulse.
          if (pending != '0 || accept) begin
            state_n = S_ON;
            cnt_n   = ON_LOAD;
            if (pending != '0 && !accept) pend_n = pending - PW'(1);
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          if (cnt_last) begin
            state_n = S_OFF;
            cnt_n   = OFF_LOAD;
          end else begin
            cnt_n = cnt - CW'(1);
          end
          if (accept) begin
            if (pending < PEND_MAX) pend_n = pending + PW'(1);
            else                    drop   = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (drop)                ovf_n = 1'b1;
    else if (clear_overflow) ovf_n = 1'b0;
    else                     ovf_n = overflow;

    bit_n = (state_n == S_ON) ? ACTIVE : ~ACTIVE;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_blink_driver.sv
// Directed bench for blink_driver. It runs a default build and an ACTIVE=0 build side by side on the same inputs.
module tb_blink_driver;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       enable = 1'b1;
  logic       evt = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       bit_out, busy, overflow;
  logic [1:0] pending;
  logic       bit_out_lo, busy_lo, overflow_lo;
  logic [1:0] pending_lo;

  int n_pass = 0;
  int n_tot  = 0;

  blink_driver u_dut (
    .clk(clk), .reset_low(reset_low), .enable(enable), .evt(evt),
    .clear_overflow(clear_overflow), .bit_out(bit_out), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  blink_driver #(.ACTIVE(1'b0)) u_dut_lo (
    .clk(clk), .reset_low(reset_low), .enable(enable), .evt(evt),
    .clear_overflow(clear_overflow), .bit_out(bit_out_lo), .busy(busy_lo),
    .pending(pending_lo), .overflow(overflow_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inverted-polarity build must always mirror the default build's pin.
  task automatic chk_bit(input string tag, input logic exp);
    chk({tag, "_bit"}, {31'd0, bit_out}, {31'd0, exp});
    chk({tag, "_bit_lo"}, {31'd0, bit_out_lo}, {31'd0, ~exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pend_exp2(input int i);
    if (i == 0) return 0;
    if (i <= 3) return i;
    if (i < 8)  return 3;
    if (i < 32) return 3 - i / 8;
    return 0;
  endfunction

  initial begin
    // reset state
    step();
    step();
    chk_bit("rst", 1'b0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pend", {30'd0, pending}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_low = 1'b1;
    step();

    // single event: 4 on, 4 off, then idle
    for (int i = 0; i <= 8; i++) begin
      evt = (i == 0);
      step();
      evt = 1'b0;
      chk_bit($sformatf("single_%0d", i), (i < 4));
      chk($sformatf("single_busy_%0d", i), {31'd0, busy}, {31'd0, (i < 8)});
      chk($sformatf("single_pend_%0d", i), {30'd0, pending}, 32'd0);
    end

    // three queued events: four back-to-back pulses
    for (int i = 0; i <= 32; i++) begin
      evt = (i <= 3);
      step();
      evt = 1'b0;
      chk_bit($sformatf("queue_%0d", i), (i < 32) && ((i % 8) < 4));
      chk($sformatf("queue_busy_%0d", i), {31'd0, busy}, {31'd0, (i < 32)});
      chk($sformatf("queue_pend_%0d", i), {30'd0, pending}, pend_exp2(i));
      chk($sformatf("queue_ovf_%0d", i), {31'd0, overflow}, 32'd0);
    end

    // five events: saturate and overflow
    for (int i = 0; i <= 4; i++) begin
      evt = 1'b1;
      step();
    end
    evt = 1'b0;
    chk("sat_pend", {30'd0, pending}, 32'd3);
    chk("sat_ovf", {31'd0, overflow}, 32'd1);
    chk_bit("sat", 1'b0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    evt = 1'b1;
    clear_overflow = 1'b1;
    step();
    evt = 1'b0;
    chk("clr_vs_drop_ovf", {31'd0, overflow}, 32'd1);
    chk("clr_vs_drop_pend", {30'd0, pending}, 32'd3);
    step();
    clear_overflow = 1'b0;
    chk("clr2_ovf", {31'd0, overflow}, 32'd0);
    // event on final OFF cycle with a full queue
    evt = 1'b1;
    step();
    evt = 1'b0;
    chk("final_off_pend", {30'd0, pending}, 32'd3);
    chk("final_off_ovf", {31'd0, overflow}, 32'd0);
    chk_bit("final_off", 1'b1);
    chk("final_off_busy", {31'd0, busy}, 32'd1);
    for (int j = 1; j <= 32; j++) begin
      step();
      if (j == 31) chk("drain_busy_31", {31'd0, busy}, 32'd1);
    end
    chk("drain_busy_end", {31'd0, busy}, 32'd0);
    chk("drain_pend_end", {30'd0, pending}, 32'd0);

    // async reset mid-ON
    evt = 1'b1;
    step();
    step();
    evt = 1'b0;
    chk("pre_rst_pend", {30'd0, pending}, 32'd1);
    #3 reset_low = 1'b0;
    #1;
    chk_bit("async_rst", 1'b0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_pend", {30'd0, pending}, 32'd0);
    #1 reset_low = 1'b1;
    evt = 1'b1;
    step();
    evt = 1'b0;
    chk_bit("post_rst_on", 1'b1);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    repeat (4) step();
    chk_bit("post_rst_off", 1'b0);
    chk("post_rst_busy_off", {31'd0, busy}, 32'd1);
    repeat (4) step();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // enable=0 while idle: nothing happens
    enable = 1'b0;
    evt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bit($sformatf("dis_idle_%0d", i), 1'b0);
      chk($sformatf("dis_idle_busy_%0d", i), {31'd0, busy}, 32'd0);
      chk($sformatf("dis_idle_ovf_%0d", i), {31'd0, overflow}, 32'd0);
    end
    // enable=0 during a pulse with two queued: all three pulses complete
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("dis_q_pend", {30'd0, pending}, 32'd2);
    enable = 1'b0;
    repeat (4) step();
    evt = 1'b0;
    chk("dis_busy_pend", {30'd0, pending}, 32'd2);
    chk("dis_busy_ovf", {31'd0, overflow}, 32'd0);
    repeat (17) step();
    chk("dis_drain_busy", {31'd0, busy}, 32'd1);
    step();
    chk("dis_drain_idle", {31'd0, busy}, 32'd0);
    chk("dis_drain_pend", {30'd0, pending}, 32'd0);
    enable = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
